servo_rom_sequencer: RTL and testbench

Reader and PWM engine for the servo pulse-width ROM. It walks the ROM address space, fetches one DATA_LEN-bit pulse-width word per step through the ROM's one-cycle registered read port, clamps the word to safe servo limits, and drives a framed servo PWM output. It sits between the servo ROM and the servo output pin.

---
 rtl/servo_rom_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_servo_rom_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/servo_rom_sequencer.sv
// servo_rom_sequencer
//
// Walks the servo pulse-width ROM, clamps each fetched word to the safe
// servo range and drives a framed PWM output. Each ROM word is held for
// FRAMES_PER_STEP frames. The next word is prefetched during the last frame
// of a step, so the PWM waveform is never interrupted by a ROM access.
//
// Ports
//   clock          in   system clock, rising-edge
//   reset          in   synchronous, active-high
//   enable         in   run request (level)
//   rom_address    out  registered ROM address
//   rom_data       in   ROM read data, valid one cycle after rom_address
//   pwm            out  registered servo pulse
//   frame_start    out  one-cycle pulse on the first cycle of every frame
//   seq_wrap       out  one-cycle pulse when the address wraps LAST_ADDR -> 0
//   current_width  out  clamped width (ticks) in effect for the current frame
//   busy           out  high in every state except IDLE
//   state_dbg      out  current FSM state (IDLE=0, FETCH=1, LATCH=2, RUN=3)
module servo_rom_sequencer #(
    parameter int ADDR_LEN        = 8,
    parameter int DATA_LEN        = 13,
    parameter int TICK_DIV        = 50,
    parameter int FRAME_TICKS     = 20000,
    parameter int MIN_WIDTH       = 1000,
    parameter int MAX_WIDTH       = 2000,
    parameter int FRAMES_PER_STEP = 5,
    parameter int LAST_ADDR       = 255
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [ADDR_LEN-1:0] rom_address,
    input  logic [DATA_LEN-1:0] rom_data,
    output logic                pwm,
    output logic                frame_start,
    output logic                seq_wrap,
    output logic [DATA_LEN-1:0] current_width,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

    localparam logic [TW-1:0]       TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [FW-1:0]       FRAME_LAST = FW'(FRAME_TICKS - 1);
    localparam logic [SW-1:0]       STEP_LAST  = SW'(FRAMES_PER_STEP - 1);
    localparam logic [ADDR_LEN-1:0] ADDR_LAST  = ADDR_LEN'(LAST_ADDR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LATCH = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                pwm_q, pwm_d;
    logic                fs_q, fs_d;
    logic                wrap_q, wrap_d;
    logic [DATA_LEN-1:0] cur_w_q, cur_w_d;
    logic [DATA_LEN-1:0] next_w_q, next_w_d;
    logic                busy_q, busy_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [FW-1:0]       ftick_q, ftick_d;
    logic [SW-1:0]       step_q, step_d;
    // Prefetch pipeline: bit 0 = address just issued, bit 1 = data on rom_data.
    logic [1:0]          pend_q, pend_d;

    logic [TW-1:0]       tick_adv;
    logic [FW-1:0]       ftick_adv;
    logic                frame_end;
    logic [SW-1:0]       step_adv;
    logic [DATA_LEN-1:0] rom_clamped;

    function automatic logic [DATA_LEN-1:0] clamp_width(input logic [DATA_LEN-1:0] w);
        if (w < DATA_LEN'(MIN_WIDTH)) return DATA_LEN'(MIN_WIDTH);
        if (w > DATA_LEN'(MAX_WIDTH)) return DATA_LEN'(MAX_WIDTH);
        return w;
    endfunction

    always_comb begin
        tick_adv    = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;
        ftick_adv   = ftick_q;
        if (tick_q == TICK_LAST) begin
            ftick_adv = (ftick_q == FRAME_LAST) ? '0 : ftick_q + 1'b1;
        end
        frame_end   = (tick_q == TICK_LAST) && (ftick_q == FRAME_LAST);
        step_adv    = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
        rom_clamped = clamp_width(rom_data);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        pwm_d    = pwm_q;
        fs_d     = 1'b0;
        wrap_d   = 1'b0;
        cur_w_d  = cur_w_q;
        next_w_d = next_w_q;
        tick_d   = tick_q;
        ftick_d  = ftick_q;
        step_d   = step_q;
        pend_d   = {pend_q[0], 1'b0};

        if (pend_q[1]) begin
            next_w_d = rom_clamped;
        end

        case (state_q)
            IDLE: begin
                pwm_d   = 1'b0;
                cur_w_d = '0;
                tick_d  = '0;
                ftick_d = '0;
                step_d  = '0;
                pend_d  = '0;
                if (enable) begin
                    addr_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LATCH;
            end
            LATCH: begin
                // Word 0 goes straight into the first frame as well as
                // into width_next.
                next_w_d = rom_clamped;
                cur_w_d  = rom_clamped;
                fs_d     = 1'b1;
                pwm_d    = (rom_clamped != '0);
                tick_d   = '0;
                ftick_d  = '0;
                step_d   = '0;
                if (STEP_LAST == '0) begin
                    addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                    wrap_d    = (addr_q == ADDR_LAST);
                    pend_d[0] = 1'b1;
                end
                state_d = RUN;
            end
            RUN: begin
                if (frame_end) begin
                    // enable is only looked at on frame boundaries so a
                    // pulse is never cut short.
                    if (!enable) begin
                        state_d = IDLE;
                        pwm_d   = 1'b0;
                        cur_w_d = '0;
                        addr_d  = '0;
                        tick_d  = '0;
                        ftick_d = '0;
                        step_d  = '0;
                        pend_d  = '0;
                    end else begin
                        fs_d    = 1'b1;
                        cur_w_d = next_w_q;
                        pwm_d   = (next_w_q != '0);
                        tick_d  = '0;
                        ftick_d = '0;
                        step_d  = step_adv;
                        if (step_adv == STEP_LAST) begin
                            addr_d    = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
                            wrap_d    = (addr_q == ADDR_LAST);
                            pend_d[0] = 1'b1;
                        end
                    end
                end else begin
                    tick_d  = tick_adv;
                    ftick_d = ftick_adv;
                    pwm_d   = (32'(ftick_adv) < 32'(cur_w_q));
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            pwm_q    <= 1'b0;
            fs_q     <= 1'b0;
            wrap_q   <= 1'b0;
            cur_w_q  <= '0;
            next_w_q <= '0;
            busy_q   <= 1'b0;
            tick_q   <= '0;
            ftick_q  <= '0;
            step_q   <= '0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pwm_q    <= pwm_d;
            fs_q     <= fs_d;
            wrap_q   <= wrap_d;
            cur_w_q  <= cur_w_d;
            next_w_q <= next_w_d;
            busy_q   <= busy_d;
            tick_q   <= tick_d;
            ftick_q  <= ftick_d;
            step_q   <= step_d;
            pend_q   <= pend_d;
        end
    end

    assign rom_address   = addr_q;
    assign pwm           = pwm_q;
    assign frame_start   = fs_q;
    assign seq_wrap      = wrap_q;
    assign current_width = cur_w_q;
    assign busy          = busy_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_servo_rom_sequencer.sv
// Directed bench for servo_rom_sequencer with small frame parameters:
// TICK_DIV=2, FRAME_TICKS=20 (40-cycle frames), clamp 3..15, two frames
// per ROM word, four ROM words. Outputs are sampled on the falling edge.
module tb_servo_rom_sequencer;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [7:0]  rom_address;
    logic [12:0] rom_data;
    logic        pwm;
    logic        frame_start;
    logic        seq_wrap;
    logic [12:0] current_width;
    logic        busy;
    logic [1:0]  state_dbg;

    logic [12:0] mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;
    int wrap_cnt = 0;
    int wrap_frame = -1;
    int wrap_at_start = 0;
    logic [31:0] exp_q [$];

    servo_rom_sequencer #(
        .ADDR_LEN(8), .DATA_LEN(13), .TICK_DIV(2), .FRAME_TICKS(20),
        .MIN_WIDTH(3), .MAX_WIDTH(15), .FRAMES_PER_STEP(2), .LAST_ADDR(3)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .rom_address(rom_address), .rom_data(rom_data),
        .pwm(pwm), .frame_start(frame_start), .seq_wrap(seq_wrap),
        .current_width(current_width), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset block
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ROM with a one-cycle registered read port
    always @(posedge clock) rom_data <= mem[rom_address];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a falling edge while IDLE; ends at the first frame_start cycle.
    task automatic start_run(input string tag);
        enable = 1'b1;
        @(negedge clock);
        check({tag, "_busy_e0"}, busy, 1);
        check({tag, "_addr_e0"}, rom_address, 0);
        check({tag, "_state_fetch"}, state_dbg, 1);
        check({tag, "_fs_e0"}, frame_start, 0);
        @(negedge clock);
        check({tag, "_state_latch"}, state_dbg, 2);
        check({tag, "_fs_e1"}, frame_start, 0);
        @(negedge clock);
        check({tag, "_fs_first"}, frame_start, 1);
        check({tag, "_pwm_first"}, pwm, 1);
    endtask

    // Called on a frame_start cycle; walks the frame until the next
    // frame_start or until busy drops. enable is lowered / raised at the
    // given in-frame cycle offsets (-1 = untouched).
    task automatic run_frame(input string tag, input int idx, input int exp_hi,
                             input int exp_addr, input int exp_w,
                             input int drop_at, input int rise_at);
        int hi, len, shape_err, cw_err;
        hi = 0; len = 0; shape_err = 0; cw_err = 0;
        check($sformatf("%s_f%0d_fs", tag, idx), frame_start, 1);
        check($sformatf("%s_f%0d_addr", tag, idx), rom_address, exp_addr);
        check($sformatf("%s_f%0d_width", tag, idx), current_width, exp_w);
        do begin
            if (len == drop_at) enable = 1'b0;
            if (len == rise_at) enable = 1'b1;
            if (pwm) hi++;
            if (pwm !== (len < exp_hi)) shape_err++;
            if (current_width !== exp_w[12:0]) cw_err++;
            if (seq_wrap) begin
                wrap_cnt++;
                wrap_frame = idx;
                wrap_at_start = (len == 0);
            end
            len++;
            @(negedge clock);
        end while (!frame_start && busy && len < 200);
        check($sformatf("%s_f%0d_len", tag, idx), len, 40);
        check($sformatf("%s_f%0d_high", tag, idx), hi, exp_hi);
        check($sformatf("%s_f%0d_shape", tag, idx), shape_err, 0);
        check($sformatf("%s_f%0d_width_hold", tag, idx), cw_err, 0);
    endtask

    // driver / sequence
    initial begin
        int s1_addr [10] = '{0, 1, 1, 2, 2, 3, 3, 0, 0, 1};
        int s1_w    [10] = '{5, 5, 3, 3, 15, 15, 15, 15, 5, 5};
        int s6_addr [8]  = '{0, 1, 1, 2, 2, 3, 3, 0};
        int s6_w    [8]  = '{3, 3, 15, 15, 3, 3, 15, 15};
        int idle_fs;
        logic [31:0] e;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = 13'd5; mem[1] = 13'd1; mem[2] = 13'd20; mem[3] = 13'd15;

        reset = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_addr", rom_address, 0);
        check("rst_pwm", pwm, 0);
        check("rst_fs", frame_start, 0);
        check("rst_wrap", seq_wrap, 0);
        check("rst_width", current_width, 0);
        check("rst_busy", busy, 0);
        check("rst_state", state_dbg, 0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_busy", busy, 0);

        // Scenario 1-3: ten frames over the whole ROM, including the wrap.
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(2 * s1_w[i]));
        start_run("s1");
        for (int f = 0; f < 10; f++) begin
            e = exp_q.pop_front();
            run_frame("s1", f, int'(e), s1_addr[f], s1_w[f], -1, -1);
        end
        check("s1_wrap_count", wrap_cnt, 1);
        check("s1_wrap_frame", wrap_frame, 7);
        check("s1_wrap_on_fs", wrap_at_start, 1);
        check("s1_busy_running", busy, 1);

        // Scenario 4: enable dropped at cycle 5 of frame 10 (word 1 -> 3).
        run_frame("s4", 10, 6, 1, 3, 5, -1);
        check("s4_busy_idle", busy, 0);
        check("s4_pwm_idle", pwm, 0);
        check("s4_fs_idle", frame_start, 0);
        check("s4_state_idle", state_dbg, 0);
        idle_fs = 0;
        repeat (6) begin
            @(negedge clock);
            if (frame_start || busy || pwm) idle_fs++;
        end
        check("s4_stays_idle", idle_fs, 0);
        start_run("s4r");
        // enable blips low mid-frame and returns before the end: keeps running
        run_frame("s4r", 0, 10, 0, 5, 3, 10);
        check("s4r_busy_after_blip", busy, 1);

        // Scenario 5: reset at cycle 3 of the high pulse of the next frame.
        check("s5_fs", frame_start, 1);
        repeat (3) @(negedge clock);
        check("s5_pwm_before", pwm, 1);
        reset = 1'b1;
        enable = 1'b0;
        @(negedge clock);
        check("s5_pwm", pwm, 0);
        check("s5_busy", busy, 0);
        check("s5_state", state_dbg, 0);
        check("s5_addr", rom_address, 0);
        check("s5_width", current_width, 0);
        check("s5_fs", frame_start, 0);
        check("s5_wrap", seq_wrap, 0);
        reset = 1'b0;
        @(negedge clock);

        // Scenario 6: clamp boundaries (0, 8191, 2, 16).
        mem[0] = 13'd0; mem[1] = 13'd8191; mem[2] = 13'd2; mem[3] = 13'd16;
        start_run("s6");
        for (int f = 0; f < 8; f++) begin
            run_frame("s6", f, 2 * s6_w[f], s6_addr[f], s6_w[f], -1, -1);
        end
        enable = 1'b0;
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
